// File: rtl/sel_arbiter.sv
// Round-robin arbiter for the 2-bit select of a 4:1 datapath mux, with a dead cycle between owners.
// Optional owner timeout is enabled by defining SEL_ARB_TIMEOUT_EN.
module sel_arbiter #(
    parameter int         MAX_HOLD = 8,
    parameter int         CNT_W    = 4,
    parameter logic [1:0] PARK_SEL = 2'b00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic [3:0] done_i,
    output logic [3:0] grant_o,
    output logic [1:0] select_o,
    output logic       busy_o,
    output logic       expired_o
);

    typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_e;

    state_e     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] select_q, select_d;
    logic       busy_q, busy_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] rrPtr_q, rrPtr_d;

    logic       winValid;
    logic [1:0] winIdx;
    logic [1:0] probeIdx;
    logic       ownerRelease;
    logic       timeout;

    if (2 ** CNT_W <= MAX_HOLD) begin : gBadCfg
        $error("sel_arbiter: CNT_W too narrow for MAX_HOLD");
    end

    // Scan downward so the requester closest to the pointer is the last, winning, assignment.
    always_comb begin
        winValid = 1'b0;
        winIdx   = rrPtr_q;
        probeIdx = rrPtr_q;
        for (int i = 3; i >= 0; i--) begin
            probeIdx = rrPtr_q + 2'(i);
            if (req_i[probeIdx]) begin
                winValid = 1'b1;
                winIdx   = probeIdx;
            end
        end
    end

    assign ownerRelease = done_i[owner_q] | ~req_i[owner_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        busy_d   = busy_q;
        owner_d  = owner_q;
        rrPtr_d  = rrPtr_q;
        case (state_q)
            IDLE: begin
                grant_d  = 4'b0000;
                select_d = PARK_SEL;
                busy_d   = 1'b0;
                if (winValid) begin
                    state_d  = GRANT;
                    grant_d  = 4'(4'b0001 << winIdx);
                    select_d = winIdx;
                    busy_d   = 1'b1;
                    owner_d  = winIdx;
                    rrPtr_d  = winIdx + 2'd1;
                end
            end
            GRANT: begin
                if (ownerRelease || timeout) begin
                    state_d  = SWITCH;
                    grant_d  = 4'b0000;
                    select_d = PARK_SEL;
                    busy_d   = 1'b1;
                end
            end
            SWITCH: begin
                state_d  = IDLE;
                grant_d  = 4'b0000;
                select_d = PARK_SEL;
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                grant_d  = 4'b0000;
                select_d = PARK_SEL;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            select_q <= PARK_SEL;
            busy_q   <= 1'b0;
            owner_q  <= 2'd0;
            rrPtr_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            rrPtr_q  <= rrPtr_d;
        end
    end

`ifdef SEL_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic             expired_q, expired_d;

    // The count reaching MAX_HOLD on this edge is the revoke point; a release on the same edge wins.
    assign timeout = (state_q == GRANT) && (holdCnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        holdCnt_d = holdCnt_q;
        expired_d = 1'b0;
        if (state_q == IDLE) begin
            holdCnt_d = '0;
        end else if (state_q == GRANT) begin
            holdCnt_d = holdCnt_q + 1'b1;
            expired_d = timeout && !ownerRelease;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            holdCnt_q <= '0;
            expired_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;
`else
    assign timeout   = 1'b0;
    assign expired_o = 1'b0;
`endif

    assign grant_o  = grant_q;
    assign select_o = select_q;
    assign busy_o   = busy_q;

endmodule
